// File: rtl/demod_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : demod_sequencer_if
// Description : Payload byte stream from the receive sequencer to the packet
//               layer. A byte transfers when data_valid and data_ready are
//               both high on a rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
interface demod_sequencer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    // Sequencer side: produces bytes, observes back-pressure.
    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    // Packet-layer side: consumes bytes, applies back-pressure.
    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/demod_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demod_sequencer
// Description : Receive-side controller for the BPSK demodulator. Arms the
//               demodulator, hunts for a sync word, reads a length header and
//               assembles MSB-first payload bytes onto a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module demod_sequencer #(
    parameter int                    SYNC_WIDTH   = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD    = 16'h2DD4,
    parameter int                    HUNT_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               abort,
    input  logic               bit_strobe,
    input  logic               bit_value,
    output logic               demod_init,
    output logic               demod_stp,
    output logic               frame_start,
    output logic               frame_done,
    output logic [7:0]         frame_len,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_overrun,
    demod_sequencer_if.master  byte_if
);

    // Hunt counter is wide enough to hold HUNT_TIMEOUT itself.
    localparam int                 c_cnt_w    = $clog2(HUNT_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_sync_cnt = c_cnt_w'(SYNC_WIDTH);
    localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(HUNT_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM_STOP = 3'd1,
        ARM_INIT = 3'd2,
        HUNT     = 3'd3,
        LEN      = 3'd4,
        PAYLOAD  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SYNC_WIDTH-1:0]   r_sync_sr;
    logic [c_cnt_w-1:0]      r_hunt_cnt;
    logic [2:0]              r_bit_cnt;
    logic [7:0]              r_byte_sr;
    logic [7:0]              r_remaining;
    logic                    r_aborting;
    logic [7:0]              r_data_out;
    logic                    r_data_valid;

    logic                    w_strobe;
    logic [SYNC_WIDTH-1:0]   w_sync_next;
    logic [c_cnt_w-1:0]      w_hunt_cnt_inc;
    logic                    w_sync_hit;
    logic [7:0]              w_byte_next;
    logic                    w_byte_last;

    logic                    w_stp_nxt;
    logic                    w_init_nxt;
    logic                    w_fstart_nxt;
    logic                    w_fdone_nxt;
    logic                    w_tout_nxt;
    logic                    w_len_load;
    logic                    w_byte_done;
    logic                    w_discard;
    logic                    w_abort_set;

    // Abort wins over a coincident strobe, so the strobe is masked here once
    // and every bit-consuming path below sees the masked version.
    assign w_strobe       = bit_strobe & ~abort;
    assign w_sync_next    = {r_sync_sr[SYNC_WIDTH-2:0], bit_value};
    assign w_hunt_cnt_inc = (r_hunt_cnt == c_timeout) ? r_hunt_cnt : r_hunt_cnt + 1'b1;
    assign w_sync_hit     = (w_sync_next == SYNC_WORD) && (w_hunt_cnt_inc >= c_sync_cnt);
    assign w_byte_next    = {r_byte_sr[6:0], bit_value};
    assign w_byte_last    = w_strobe && (r_bit_cnt == 3'd7);

    assign byte_if.data_out   = r_data_out;
    assign byte_if.data_valid = r_data_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the next value of every registered pulse output.
    always_comb begin
        w_state_nxt  = r_state;
        w_stp_nxt    = 1'b0;
        w_init_nxt   = 1'b0;
        w_fstart_nxt = 1'b0;
        w_fdone_nxt  = 1'b0;
        w_tout_nxt   = 1'b0;
        w_len_load   = 1'b0;
        w_byte_done  = 1'b0;
        w_discard    = 1'b0;
        w_abort_set  = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = ARM_STOP;
                    w_stp_nxt   = 1'b1;
                end
            end
            ARM_STOP: begin
                w_state_nxt = ARM_INIT;
                w_init_nxt  = 1'b1;
            end
            ARM_INIT: begin
                w_state_nxt = HUNT;
            end
            HUNT: begin
                if (w_strobe) begin
                    if (w_sync_hit) begin
                        w_state_nxt  = LEN;
                        w_fstart_nxt = 1'b1;
                    end else if (w_hunt_cnt_inc == c_timeout) begin
                        w_state_nxt = IDLE;
                        w_tout_nxt  = 1'b1;
                        w_stp_nxt   = 1'b1;
                    end
                end
            end
            LEN: begin
                if (w_byte_last) begin
                    w_len_load = 1'b1;
                    if (w_byte_next == 8'd0) begin
                        w_state_nxt = DONE;
                        w_stp_nxt   = 1'b1;
                        w_fdone_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_byte_last) begin
                    w_byte_done = 1'b1;
                    if (r_remaining == 8'd1) begin
                        w_state_nxt = DONE;
                        w_stp_nxt   = 1'b1;
                        w_fdone_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                // DONE doubles as the stop cycle of an abort; only then (or on
                // a fresh abort here) is the pending output byte thrown away.
                w_state_nxt = IDLE;
                w_discard   = r_aborting | abort;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (abort && (r_state != IDLE) && (r_state != DONE)) begin
            w_state_nxt = DONE;
            w_stp_nxt   = 1'b1;
            w_init_nxt  = 1'b0;
            w_abort_set = 1'b1;
        end
    end

    // Registered control and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demod_stp   <= 1'b0;
            demod_init  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
            r_aborting  <= 1'b0;
        end else begin
            demod_stp   <= w_stp_nxt;
            demod_init  <= w_init_nxt;
            frame_start <= w_fstart_nxt;
            frame_done  <= w_fdone_nxt;
            err_timeout <= w_tout_nxt;
            err_overrun <= w_byte_done & r_data_valid & ~byte_if.data_ready;
            busy        <= (w_state_nxt != IDLE);
            r_aborting  <= w_abort_set;
        end
    end

    // Sync hunt shift register and saturating bit counter, cleared on the way into HUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_sr  <= '0;
            r_hunt_cnt <= '0;
        end else if (r_state == ARM_INIT) begin
            r_sync_sr  <= '0;
            r_hunt_cnt <= '0;
        end else if ((r_state == HUNT) && w_strobe) begin
            r_sync_sr  <= w_sync_next;
            r_hunt_cnt <= w_hunt_cnt_inc;
        end
    end

    // Byte assembly for the length header and payload, plus remaining-byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_byte_sr   <= 8'd0;
            r_remaining <= 8'd0;
            frame_len   <= 8'd0;
        end else begin
            if (r_state == HUNT) begin
                r_bit_cnt <= 3'd0;
            end else if (((r_state == LEN) || (r_state == PAYLOAD)) && w_strobe) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_byte_sr <= w_byte_next;
            end
            if (w_len_load) begin
                frame_len   <= w_byte_next;
                r_remaining <= w_byte_next;
            end else if (w_byte_done) begin
                r_remaining <= r_remaining - 8'd1;
            end
        end
    end

    // Output byte holding register: load when free or being drained, else drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= 8'd0;
            r_data_valid <= 1'b0;
        end else if (w_discard) begin
            r_data_valid <= 1'b0;
        end else if (w_byte_done && (!r_data_valid || byte_if.data_ready)) begin
            r_data_out   <= w_byte_next;
            r_data_valid <= 1'b1;
        end else if (r_data_valid && byte_if.data_ready) begin
            r_data_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demod_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demod_sequencer
// Description : Directed self-checking bench for demod_sequencer: arming,
//               normal frame, zero-length frame, hunt timeout, overrun,
//               abort and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demod_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       abort;
    logic       bit_strobe;
    logic       bit_value;
    logic       demod_init;
    logic       demod_stp;
    logic       frame_start;
    logic       frame_done;
    logic [7:0] frame_len;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;

    demod_sequencer_if bif();

    int n_checks;
    int n_errors;
    int n_fstart;
    int n_fdone;
    int n_tout;
    logic [7:0] rx_q[$];

    demod_sequencer #(
        .SYNC_WIDTH   (16),
        .SYNC_WORD    (16'h2DD4),
        .HUNT_TIMEOUT (4096)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .abort       (abort),
        .bit_strobe  (bit_strobe),
        .bit_value   (bit_value),
        .demod_init  (demod_init),
        .demod_stp   (demod_stp),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .byte_if     (bif.master)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and accepted-byte log, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_start) n_fstart++;
        if (frame_done)  n_fdone++;
        if (err_timeout) n_tout++;
        if (bif.data_valid && bif.data_ready) rx_q.push_back(bif.data_out);
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns one cycle later (cycle M+1).
    task automatic send_bit(input logic b);
        bit_strobe = 1'b1;
        bit_value  = b;
        tick();
        bit_strobe = 1'b0;
        bit_value  = 1'b0;
    endtask

    // MSB-first; gap idle cycles between bits, none after the last.
    task automatic send_bits(input logic [15:0] v, input int nbits, input int gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (i != nbits - 1) repeat (gap) tick();
            send_bit(v[i]);
        end
    endtask

    task automatic arm();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_fstart   = 0;
        n_fdone    = 0;
        n_tout     = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        abort      = 1'b0;
        bit_strobe = 1'b0;
        bit_value  = 1'b0;
        bif.data_ready = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_busy",  {31'd0, busy},           32'd0);
        check("rst_stp",   {31'd0, demod_stp},      32'd0);
        check("rst_init",  {31'd0, demod_init},     32'd0);
        check("rst_valid", {31'd0, bif.data_valid}, 32'd0);
        check("rst_len",   {24'd0, frame_len},      32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- arm timing ----------------
        enable = 1'b1;                 // cycle N
        tick();                        // N+1
        enable = 1'b0;
        check("arm_stp_n1",  {31'd0, demod_stp},  32'd1);
        check("arm_busy_n1", {31'd0, busy},       32'd1);
        check("arm_init_n1", {31'd0, demod_init}, 32'd0);
        tick();                        // N+2
        check("arm_init_n2", {31'd0, demod_init}, 32'd1);
        check("arm_stp_n2",  {31'd0, demod_stp},  32'd0);
        tick();                        // N+3, hunting
        check("arm_init_n3", {31'd0, demod_init},  32'd0);
        check("arm_fs_n3",   {31'd0, frame_start}, 32'd0);
        check("arm_busy_n3", {31'd0, busy},        32'd1);

        // ---------------- normal frame ----------------
        send_bits(16'h0005, 3, 3);     // noise 1,0,1
        repeat (3) tick();
        send_bits(16'h2DD4, 16, 3);
        check("f1_start",    {31'd0, frame_start}, 32'd1);
        repeat (3) tick();
        send_bits(16'h0002, 8, 2);
        check("f1_len",      {24'd0, frame_len},   32'd2);
        check("f1_nvalid",   {31'd0, bif.data_valid}, 32'd0);
        tick();
        send_bits(16'h00A5, 8, 0);     // back-to-back strobes
        check("f1_b0_valid", {31'd0, bif.data_valid}, 32'd1);
        check("f1_b0_data",  {24'd0, bif.data_out},   32'h0A5);
        repeat (4) tick();
        send_bits(16'h003C, 8, 1);
        check("f1_b1_data",  {24'd0, bif.data_out},   32'h03C);
        check("f1_done",     {31'd0, frame_done},     32'd1);
        check("f1_stp",      {31'd0, demod_stp},      32'd1);
        tick();
        check("f1_busy_off", {31'd0, busy},           32'd0);
        check("f1_valid_off",{31'd0, bif.data_valid}, 32'd0);
        check("f1_nstart",   n_fstart,                1);
        check("f1_nbytes",   rx_q.size(),             2);
        if (rx_q.size() == 2) begin
            check("f1_q0", {24'd0, rx_q[0]}, 32'h0A5);
            check("f1_q1", {24'd0, rx_q[1]}, 32'h03C);
        end

        // ---------------- zero-length frame ----------------
        arm();
        send_bits(16'h2DD4, 16, 2);
        tick();
        send_bits(16'h0000, 8, 2);
        check("z_done",   {31'd0, frame_done},     32'd1);
        check("z_stp",    {31'd0, demod_stp},      32'd1);
        check("z_len",    {24'd0, frame_len},      32'd0);
        check("z_valid",  {31'd0, bif.data_valid}, 32'd0);
        tick();
        check("z_busy",   {31'd0, busy},           32'd0);
        check("z_nbytes", rx_q.size(),             2);
        check("z_ndone",  n_fdone,                 2);

        // ---------------- hunt timeout ----------------
        arm();
        for (int i = 0; i < 4095; i++) send_bit(1'b0);
        check("to_early",  n_tout,              0);
        check("to_busy",   {31'd0, busy},       32'd1);
        send_bit(1'b0);                // 4096th strobe
        check("to_err",    {31'd0, err_timeout}, 32'd1);
        check("to_stp",    {31'd0, demod_stp},   32'd1);
        tick();
        check("to_pulse",  {31'd0, err_timeout}, 32'd0);
        check("to_idle",   {31'd0, busy},        32'd0);

        // ---------------- overrun ----------------
        bif.data_ready = 1'b0;
        arm();
        send_bits(16'h2DD4, 16, 1);
        tick();
        send_bits(16'h0002, 8, 1);
        tick();
        send_bits(16'h00A5, 8, 1);
        check("ov_b0_valid", {31'd0, bif.data_valid}, 32'd1);
        check("ov_b0_data",  {24'd0, bif.data_out},   32'h0A5);
        tick();
        send_bits(16'h003C, 8, 1);
        check("ov_err",      {31'd0, err_overrun},    32'd1);
        check("ov_held",     {24'd0, bif.data_out},   32'h0A5);
        check("ov_done",     {31'd0, frame_done},     32'd1);
        tick();
        check("ov_retain",   {31'd0, bif.data_valid}, 32'd1);
        check("ov_busy",     {31'd0, busy},           32'd0);
        bif.data_ready = 1'b1;
        tick();
        check("ov_drain",    {31'd0, bif.data_valid}, 32'd0);
        check("ov_nbytes",   rx_q.size(),             3);
        if (rx_q.size() == 3) check("ov_q2", {24'd0, rx_q[2]}, 32'h0A5);

        // ---------------- abort during payload ----------------
        bif.data_ready = 1'b0;
        arm();
        send_bits(16'h2DD4, 16, 1);
        tick();
        send_bits(16'h0003, 8, 1);
        tick();
        send_bits(16'h0011, 8, 1);
        check("ab_valid0", {31'd0, bif.data_valid}, 32'd1);
        tick();
        send_bits(16'h007F, 7, 1);
        tick();
        abort = 1'b1;                  // same cycle as the 8th strobe
        send_bit(1'b1);
        abort = 1'b0;
        check("ab_stp",    {31'd0, demod_stp},   32'd1);
        check("ab_novr",   {31'd0, err_overrun}, 32'd0);
        check("ab_ndone",  {31'd0, frame_done},  32'd0);
        tick();
        check("ab_busy",   {31'd0, busy},           32'd0);
        check("ab_valid",  {31'd0, bif.data_valid}, 32'd0);
        check("ab_fdcnt",  n_fdone,                 3);
        check("ab_len",    {24'd0, frame_len},      32'd3);

        // ---------------- asynchronous reset mid-hunt ----------------
        bif.data_ready = 1'b1;
        arm();
        send_bits(16'h0016, 5, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",  {31'd0, busy},       32'd0);
        check("ar_len",   {24'd0, frame_len},  32'd0);
        check("ar_stp",   {31'd0, demod_stp},  32'd0);
        check("ar_init",  {31'd0, demod_init}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check("ar_post_stp",  {31'd0, demod_stp}, 32'd0);
        check("ar_post_busy", {31'd0, busy},      32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
